select_accum: RTL and testbench

Downstream consumer of the channel-select mask store. Sweeps one frame of 256 per-channel samples, reads back each channel's select bit through the mask store's read port (rd_en/rd_addr -> data_out/data_out_valid, 1-cycle latency), and accumulates the selected samples. Emits one signed sum plus a selected-channel count per frame to the interferometer phase-processing stage.

---
 rtl/select_accum.sv | 222 ++++++++++++++++++++++
 tb/tb_select_accum.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_accum.sv
// select_accum: sweeps one 256-channel frame, fetches each channel's select
// bit from the mask store (1-cycle read latency) and accumulates the selected
// samples into a signed sum, a selected-channel count and, optionally, a peak.
// Optional feature macro: SEL_PEAK_EN (signed maximum of selected samples).
//
// Handshake summary: sample_valid has no backpressure; every sample seen
// with sample_valid=1 in RUN is taken. sel_rd_en is a one-cycle read strobe
// (the mask store has no ready of its own); sel_bit is meaningful only when
// sel_bit_valid=1 two cycles after the sample was taken. sel_rd_ready is a
// level: low means the mask is being rewritten and any frame in progress is
// abandoned.
module select_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sel_rd_ready,
  output logic              sel_rd_en,
  output logic [7:0]        sel_rd_addr,
  input  logic              sel_bit,
  input  logic              sel_bit_valid,
  output logic [ACC_W-1:0]  sum_out,
  output logic [8:0]        count_out,
  output logic [DATA_W-1:0] peak_out,
  output logic              result_valid,
  output logic              busy,
  output logic              frame_drop,
  output logic              frame_abort,
  output logic              sync_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [7:0]        r_ch;

  // Two-stage delay pipe: stage 1 drives the mask read, stage 2 lines up
  // with the returned select bit.
  logic              r_s1_valid;
  logic [7:0]        r_s1_ch;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s2_valid;
  logic [7:0]        r_s2_ch;
  logic [DATA_W-1:0] r_s2_data;

  logic [ACC_W-1:0]  r_sum;
  logic [8:0]        r_cnt;
  logic [ACC_W-1:0]  r_sum_out;
  logic [8:0]        r_cnt_out;
  logic              r_result_valid;
  logic              r_frame_drop;
  logic              r_frame_abort;
  logic              r_sync_err;

  logic              w_start;
  logic              w_drop;
  logic              w_abort;
  logic              w_accept;
  logic              w_hit;
  logic              w_miss;
  logic              w_last;
  logic [ACC_W-1:0]  w_sext;
  logic [ACC_W-1:0]  w_sum_next;
  logic [8:0]        w_cnt_next;

  // Event decode for the current cycle; abort outranks everything in a frame.
  always_comb begin
    w_start  = (r_state == ST_IDLE) && frame_start && sel_rd_ready;
    w_drop   = (r_state == ST_IDLE) && frame_start && !sel_rd_ready;
    w_abort  = (r_state != ST_IDLE) && !sel_rd_ready;
    w_accept = (r_state == ST_RUN) && sample_valid && !w_abort;
    w_hit    = r_s2_valid && sel_bit_valid && sel_bit;
    w_miss   = r_s2_valid && !sel_bit_valid;
    w_last   = (r_state == ST_DRAIN) && r_s2_valid && (r_s2_ch == 8'hFF) && !w_abort;
    w_sext   = {{(ACC_W-DATA_W){r_s2_data[DATA_W-1]}}, r_s2_data};
    w_sum_next = w_hit ? (r_sum + w_sext) : r_sum;
    w_cnt_next = r_cnt + {8'd0, w_hit};
  end

  // Frame sequencer and channel counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_ch    <= 8'd0;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_ch    <= 8'd0;
          end else if (w_accept) begin
            r_ch <= r_ch + 8'd1;
            if (r_ch == 8'hFF) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_abort || w_last) begin
            r_state <= ST_IDLE;
            r_ch    <= 8'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Delay pipe; start and abort both empty it so no stale channel survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= 8'd0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ch    <= 8'd0;
      r_s2_data  <= '0;
    end else if (w_abort || w_start) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_ch    <= r_ch;
      r_s1_data  <= sample_in;
      r_s2_valid <= r_s1_valid;
      r_s2_ch    <= r_s1_ch;
      r_s2_data  <= r_s1_data;
    end
  end

  // Running sum and count of the frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= 9'd0;
    end else if (w_start) begin
      r_sum <= '0;
      r_cnt <= 9'd0;
    end else if (!w_abort) begin
      r_sum <= w_sum_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Result registers, status pulses and the sticky missing-bit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_out      <= '0;
      r_cnt_out      <= 9'd0;
      r_result_valid <= 1'b0;
      r_frame_drop   <= 1'b0;
      r_frame_abort  <= 1'b0;
      r_sync_err     <= 1'b0;
    end else begin
      r_result_valid <= w_last;
      r_frame_drop   <= w_drop;
      r_frame_abort  <= w_abort;
      if (w_last) begin
        r_sum_out <= w_sum_next;
        r_cnt_out <= w_cnt_next;
      end
      if (w_start)
        r_sync_err <= 1'b0;
      else if (w_miss && !w_abort)
        r_sync_err <= 1'b1;
    end
  end

`ifdef SEL_PEAK_EN
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] r_peak_out;
  logic [DATA_W-1:0] w_peak_next;

  // A frame starts its peak at the most negative value so an empty frame
  // reports exactly that.
  always_comb begin
    w_peak_next = r_peak;
    if (w_hit && ($signed(r_s2_data) > $signed(r_peak))) w_peak_next = r_s2_data;
  end

  // Peak tracking and its result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak     <= '0;
      r_peak_out <= '0;
    end else begin
      if (w_start)
        r_peak <= {1'b1, {(DATA_W-1){1'b0}}};
      else if (!w_abort)
        r_peak <= w_peak_next;
      if (w_last) r_peak_out <= w_peak_next;
    end
  end

  assign peak_out = r_peak_out;
`else
  assign peak_out = '0;
`endif

  assign sel_rd_en    = r_s1_valid;
  assign sel_rd_addr  = r_s1_ch;
  assign sum_out      = r_sum_out;
  assign count_out    = r_cnt_out;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != ST_IDLE);
  assign frame_drop   = r_frame_drop;
  assign frame_abort  = r_frame_abort;
  assign sync_err     = r_sync_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_select_accum.sv
// Testbench for select_accum: table-driven frames, hand-written corner
// sequences (abort, drop, missing bit, mid-frame reset) and random frames
// checked against a per-frame arithmetic reference model.
`timescale 1ns/1ps
module tb_select_accum;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              sel_rd_ready = 1'b1;
  logic              sel_rd_en;
  logic [7:0]        sel_rd_addr;
  logic              sel_bit = 1'b0;
  logic              sel_bit_valid = 1'b0;
  logic [ACC_W-1:0]  sum_out;
  logic [8:0]        count_out;
  logic [DATA_W-1:0] peak_out;
  logic              result_valid;
  logic              busy;
  logic              frame_drop;
  logic              frame_abort;
  logic              sync_err;
  logic [1:0]        dbg_state;

  select_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .sample_in(sample_in),
    .sample_valid(sample_valid), .sel_rd_ready(sel_rd_ready),
    .sel_rd_en(sel_rd_en), .sel_rd_addr(sel_rd_addr), .sel_bit(sel_bit),
    .sel_bit_valid(sel_bit_valid), .sum_out(sum_out), .count_out(count_out),
    .peak_out(peak_out), .result_valid(result_valid), .busy(busy),
    .frame_drop(frame_drop), .frame_abort(frame_abort), .sync_err(sync_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- frame content (bench-owned) ----------------
  logic               sel_map  [256];
  logic               drop_map [256];
  logic signed [15:0] samp     [256];

  // ---------------- mask-store model ----------------
  logic       hold_en   = 1'b0;
  logic [7:0] hold_addr = 8'd0;
  always @(negedge clk) begin
    hold_en   = sel_rd_en;
    hold_addr = sel_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    sel_bit_valid = hold_en && !drop_map[hold_addr];
    sel_bit       = hold_en && sel_map[hold_addr];
  end

  // ---------------- monitor ----------------
  int rv_cnt = 0, abort_cnt = 0, drop_cnt = 0, rd_cnt = 0, addr_bad = 0;
  int res_cyc = 0, rd_next = 0;
  logic busy_at_res = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        rv_cnt++;
        res_cyc = cyc;
        busy_at_res = busy;
      end
      if (frame_abort) abort_cnt++;
      if (frame_drop)  drop_cnt++;
      if (!busy) rd_next = 0;
      if (sel_rd_en) begin
        if (int'(sel_rd_addr) != rd_next) addr_bad++;
        rd_next = (rd_next + 1) % 256;
        rd_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: a frame's result is a plain fold over the channel arrays.
  longint m_sum; int m_cnt; int m_pk; bit m_se;
  task automatic model();
    m_sum = 0; m_cnt = 0; m_pk = -32768; m_se = 0;
    for (int i = 0; i < 256; i++) begin
      if (drop_map[i]) m_se = 1;
      else if (sel_map[i]) begin
        m_sum += longint'(samp[i]);
        m_cnt++;
        if (int'(samp[i]) > m_pk) m_pk = int'(samp[i]);
      end
    end
`ifndef SEL_PEAK_EN
    m_pk = 0;
`endif
  endtask

  longint last_sum = 0; int last_cnt = 0; int last_pk = 0;

  // ---------------- driver tasks ----------------
  int last_cyc = 0;

  task automatic start_frame(input bit junk);
    @(negedge clk);
    frame_start = 1'b1; sample_valid = junk; sample_in = 16'd1000;
    @(negedge clk);
    frame_start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic send_ch(input int ch, input int gap);
    sample_valid = 1'b1;
    sample_in    = samp[ch];
    if (ch == 255) last_cyc = cyc;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // gap_mode: 0 continuous, 1 one sample every third cycle, 2 random gaps
  task automatic run_frame(input string tag, input int gap_mode, input bit junk);
    int rv0, rd0, ab0, g, waited;
    model();
    exp_q.push_back(ACC_W'(m_sum));
    rv0 = rv_cnt; rd0 = rd_cnt; ab0 = addr_bad;
    start_frame(junk);
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_sync_clr"}, sync_err, 0);
    for (int ch = 0; ch < 256; ch++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : $urandom_range(0, 2);
      send_ch(ch, g);
    end
    waited = 0;
    while (rv_cnt == rv0 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_rv_pulses"}, rv_cnt - rv0, 1);
    chk({tag, "_latency"}, res_cyc - last_cyc, 3);
    chk({tag, "_busy_at_res"}, busy_at_res, 0);
    chk({tag, "_sum"}, $signed(sum_out), $signed(exp_q.pop_front()));
    chk({tag, "_count"}, count_out, m_cnt);
    chk({tag, "_peak"}, $signed(peak_out), m_pk);
    chk({tag, "_sync_err"}, sync_err, m_se);
    chk({tag, "_rd_count"}, rd_cnt - rd0, 256);
    chk({tag, "_rd_addr_bad"}, addr_bad - ab0, 0);
    last_sum = m_sum; last_cnt = m_cnt; last_pk = m_pk;
  endtask

  task automatic clear_maps();
    for (int i = 0; i < 256; i++) begin
      sel_map[i] = 1'b0; drop_map[i] = 1'b0; samp[i] = '0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int sel_lo; int sel_hi; int kind; int gap;
    int exp_sum; int exp_cnt; int exp_peak;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int rv0, ab0, d0, pk_exp;
    vecs[0] = '{sel_lo: 10, sel_hi: 19,  kind: 0, gap: 0, exp_sum: 50,    exp_cnt: 10,  exp_peak: 5};
    vecs[1] = '{sel_lo: 0,  sel_hi: 255, kind: 1, gap: 0, exp_sum: 32640, exp_cnt: 256, exp_peak: 255};
    vecs[2] = '{sel_lo: 0,  sel_hi: 255, kind: 1, gap: 1, exp_sum: 32640, exp_cnt: 256, exp_peak: 255};
    vecs[3] = '{sel_lo: 0,  sel_hi: 3,   kind: 2, gap: 0, exp_sum: -23,   exp_cnt: 4,   exp_peak: -3};
    clear_maps();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sum", sum_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_peak", peak_out, 0);
    chk("rst_flags", {result_valid, busy, frame_drop, frame_abort, sync_err, sel_rd_en}, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      clear_maps();
      for (int i = 0; i < 256; i++) begin
        sel_map[i] = (i >= vecs[v].sel_lo) && (i <= vecs[v].sel_hi);
        samp[i] = (vecs[v].kind == 0) ? 16'sd5 : (vecs[v].kind == 1) ? 16'(i) : 16'sd100;
      end
      if (vecs[v].kind == 2) begin
        samp[0] = -16'sd7; samp[1] = -16'sd3; samp[2] = -16'sd9; samp[3] = -16'sd4;
      end
      run_frame($sformatf("vec%0d", v), vecs[v].gap, v[0]);
`ifdef SEL_PEAK_EN
      pk_exp = vecs[v].exp_peak;
`else
      pk_exp = 0;
`endif
      chk($sformatf("vec%0d_tbl_sum", v), $signed(sum_out), vecs[v].exp_sum);
      chk($sformatf("vec%0d_tbl_count", v), count_out, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_tbl_peak", v), $signed(peak_out), pk_exp);
    end

    // missing select bit for channel 50: excluded and flagged
    clear_maps();
    for (int i = 0; i < 256; i++) begin sel_map[i] = 1'b1; samp[i] = 16'(i); end
    drop_map[50] = 1'b1;
    run_frame("miss50", 0, 1'b0);
    chk("miss50_tbl_sum", $signed(sum_out), 32590);

    // abort after channel 100: outputs keep the previous frame's result
    drop_map[50] = 1'b0;
    rv0 = rv_cnt; ab0 = abort_cnt;
    start_frame(1'b0);
    for (int ch = 0; ch <= 100; ch++) send_ch(ch, 0);
    sel_rd_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pulse", abort_cnt - ab0, 1);
    chk("abort_no_result", rv_cnt - rv0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum_held", $signed(sum_out), last_sum);
    chk("abort_count_held", count_out, last_cnt);
    chk("abort_peak_held", $signed(peak_out), last_pk);

    // frame_start while mask store not readable
    d0 = drop_cnt; ab0 = abort_cnt;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("drop_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("drop_pulse", drop_cnt - d0, 1);
    chk("drop_no_abort", abort_cnt - ab0, 0);
    chk("drop_busy_after", busy, 0);
    sel_rd_ready = 1'b1;
    @(negedge clk);

    // random frames against the reference model
    for (int f = 0; f < 5; f++) begin
      clear_maps();
      for (int i = 0; i < 256; i++) begin
        sel_map[i]  = ($urandom_range(0, 1) == 1);
        samp[i]     = 16'($urandom);
        drop_map[i] = ($urandom_range(0, 99) < 2);
      end
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of a frame
    rv0 = rv_cnt; ab0 = abort_cnt;
    start_frame(1'b0);
    for (int ch = 0; ch < 50; ch++) send_ch(ch, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum_out, 0);
    chk("midrst_count", count_out, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_pulses", (rv_cnt - rv0) + (abort_cnt - ab0), 0);
    chk("midrst_state", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
